// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES types and round-count constants for the round controller and its environment.
package aes_pkg;

  localparam int unsigned AES128_NR = 10;
  localparam int unsigned AES192_NR = 12;
  localparam int unsigned AES256_NR = 14;

  // Byte 15 occupies bits [127:120] and is the first byte of the block.
  typedef logic [15:0][7:0] aes_state_t;

  typedef enum logic [1:0] {
    StIdle,
    StKey,
    StOut
  } aes_fsm_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block/key/datapath bundle between the round controller (slave) and its environment (master).
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_block;
  logic       abort;
  logic       busy;
  logic       rk_req;
  logic [3:0] rk_idx;
  logic       rk_ack;
  aes_state_t rk_data;
  aes_state_t dp_state;
  aes_state_t dp_key;
  logic       dp_final;
  aes_state_t dp_result;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_block;

  modport master (
    output in_valid, in_block, abort, rk_ack, rk_data, dp_result, out_ready,
    input  in_ready, busy, rk_req, rk_idx, dp_state, dp_key, dp_final, out_valid, out_block
  );

  modport slave (
    input  in_valid, in_block, abort, rk_ack, rk_data, dp_result, out_ready,
    output in_ready, busy, rk_req, rk_idx, dp_state, dp_key, dp_final, out_valid, out_block
  );

endinterface

// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer: fetches NR+1 round keys, steps an external round datapath
// and holds the state register; the datapath itself lives outside this block.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES128_NR
) (
  input logic           clk,
  input logic           rst_n,
  aes_round_ctrl_if.slave bus
);

  localparam logic [3:0] LastRnd = 4'(NR);

  aes_fsm_e   r_fsm, w_fsm_nxt;
  logic [3:0] r_rnd, w_rnd_nxt;
  aes_state_t r_state, w_state_nxt;
  logic       w_last;

  assign w_last = (r_rnd == LastRnd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= StIdle;
      r_rnd   <= '0;
      r_state <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_rnd   <= w_rnd_nxt;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_rnd_nxt   = r_rnd;
    w_state_nxt = r_state;
    unique case (r_fsm)
      StIdle: begin
        if (bus.in_valid) begin
          w_fsm_nxt   = StKey;
          w_rnd_nxt   = '0;
          w_state_nxt = bus.in_block;
        end
      end
      StKey: begin
        // Abort wins over a key ack arriving in the same cycle.
        if (bus.abort) begin
          w_fsm_nxt = StIdle;
          w_rnd_nxt = '0;
        end else if (bus.rk_ack) begin
          // Round 0 is the plain whitening XOR; the datapath is bypassed.
          w_state_nxt = (r_rnd == '0) ? (r_state ^ bus.rk_data) : bus.dp_result;
          if (w_last) begin
            w_fsm_nxt = StOut;
            w_rnd_nxt = '0;
          end else begin
            w_rnd_nxt = r_rnd + 4'd1;
          end
        end
      end
      StOut: begin
        if (bus.abort || bus.out_ready) begin
          w_fsm_nxt = StIdle;
        end
      end
      default: begin
        w_fsm_nxt = StIdle;
        w_rnd_nxt = '0;
      end
    endcase
  end

  assign bus.in_ready  = (r_fsm == StIdle);
  assign bus.busy      = (r_fsm != StIdle);
  assign bus.rk_req    = (r_fsm == StKey);
  assign bus.rk_idx    = r_rnd;
  assign bus.dp_final  = (r_fsm == StKey) && w_last;
  assign bus.dp_state  = r_state;
  assign bus.dp_key    = bus.rk_data;
  assign bus.out_valid = (r_fsm == StOut);
  assign bus.out_block = r_state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: NR=10 and NR=14 instances sharing one stimulus set,
// with a behavioural AES round datapath and key tables standing in for the key schedule.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst_n;
  logic sel14;
  logic in_valid, abort, rk_ack, out_ready;
  logic [127:0] in_block;

  logic [127:0] keytab10 [16];
  logic [127:0] keytab14 [16];
  logic [127:0] exp_q [$];

  int n_checks;
  int n_pass;

  aes_round_ctrl_if b10 ();
  aes_round_ctrl_if b14 ();

  aes_round_ctrl #(.NR(AES128_NR)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(b10.slave));
  aes_round_ctrl #(.NR(AES256_NR)) u_dut14 (.clk(clk), .rst_n(rst_n), .bus(b14.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural AES round datapath ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    logic [7:0] sq  = a;
    // a^254 is the field inverse (0 maps to 0)
    for (int i = 0; i < 8; i++) begin
      if (i != 0) inv = gmul(inv, sq);
      sq = gmul(sq, sq);
    end
    return inv ^ ((inv << 1) | (inv >> 7)) ^ ((inv << 2) | (inv >> 6))
               ^ ((inv << 3) | (inv >> 5)) ^ ((inv << 4) | (inv >> 4)) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [127:0] t;
    logic [127:0] u;
    logic [7:0] a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) u[127-8*(r+4*c) -: 8] = t[127-8*(r+4*((c+r)%4)) -: 8];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = u[127-32*c -: 8];
        a1 = u[119-32*c -: 8];
        a2 = u[111-32*c -: 8];
        a3 = u[103-32*c -: 8];
        u[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        u[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        u[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        u[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    return u ^ k;
  endfunction

  function automatic void expand128(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) keytab10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] model(input logic [127:0] pt, input logic use14);
    int nr = use14 ? 14 : 10;
    logic [127:0] s;
    s = pt ^ (use14 ? keytab14[0] : keytab10[0]);
    for (int r = 1; r <= nr; r++) s = aes_round(s, use14 ? keytab14[r] : keytab10[r], r == nr);
    return s;
  endfunction

  // ---------------- environment wiring ----------------
  assign b10.in_valid  = in_valid & ~sel14;
  assign b14.in_valid  = in_valid & sel14;
  assign b10.in_block  = in_block;
  assign b14.in_block  = in_block;
  assign b10.abort     = abort;
  assign b14.abort     = abort;
  assign b10.rk_ack    = rk_ack;
  assign b14.rk_ack    = rk_ack;
  assign b10.out_ready = out_ready;
  assign b14.out_ready = out_ready;
  assign b10.rk_data   = keytab10[b10.rk_idx];
  assign b14.rk_data   = keytab14[b14.rk_idx];
  assign b10.dp_result = aes_round(b10.dp_state, b10.dp_key, b10.dp_final);
  assign b14.dp_result = aes_round(b14.dp_state, b14.dp_key, b14.dp_final);

  logic         m_in_ready, m_busy, m_rk_req, m_dp_final, m_out_valid;
  logic [3:0]   m_rk_idx;
  logic [127:0] m_out_block, m_dp_state;

  assign m_in_ready  = sel14 ? b14.in_ready  : b10.in_ready;
  assign m_busy      = sel14 ? b14.busy      : b10.busy;
  assign m_rk_req    = sel14 ? b14.rk_req    : b10.rk_req;
  assign m_dp_final  = sel14 ? b14.dp_final  : b10.dp_final;
  assign m_out_valid = sel14 ? b14.out_valid : b10.out_valid;
  assign m_rk_idx    = sel14 ? b14.rk_idx    : b10.rk_idx;
  assign m_out_block = sel14 ? b14.out_block : b10.out_block;
  assign m_dp_state  = sel14 ? b14.dp_state  : b10.dp_state;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard consumer: every output handshake must match the oldest pending block.
  always @(negedge clk) begin
    if (rst_n && m_out_valid && out_ready) begin
      check("sb_pending", 128'(exp_q.size() > 0), 128'd1);
      if (exp_q.size() > 0) begin
        check("ciphertext", m_out_block, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  128'(m_in_ready),  128'd1);
    check({tag, "_busy"},      128'(m_busy),      128'd0);
    check({tag, "_rk_req"},    128'(m_rk_req),    128'd0);
    check({tag, "_rk_idx"},    128'(m_rk_idx),    128'd0);
    check({tag, "_dp_final"},  128'(m_dp_final),  128'd0);
    check({tag, "_out_valid"}, 128'(m_out_valid), 128'd0);
    check({tag, "_out_block"}, m_out_block,       128'd0);
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] exp, input logic abort_idle);
    int n = 0;
    in_block = pt;
    in_valid = 1'b1;
    while (!m_in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", 128'(m_in_ready), 128'd1);
    abort = abort_idle;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    check("accepted_busy", 128'(m_busy), 128'd1);
  endtask

  // Drives the key phase; abort_rnd/reset_rnd select a cancel point (-1 for none).
  task automatic run_key(input int nr, input logic [15:0] mask, input int abort_rnd,
                         input int reset_rnd, output int k);
    int exp_rnd = 0;
    int stalled = 0;
    k = 0;
    while (!m_out_valid && k < 100) begin
      check("rk_req", 128'(m_rk_req), 128'd1);
      check("rk_idx", 128'(m_rk_idx), 128'(exp_rnd));
      check("dp_final", 128'(m_dp_final), 128'(exp_rnd == nr));
      if (exp_rnd == abort_rnd) begin
        abort  = 1'b1;
        rk_ack = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_ready", 128'(m_in_ready), 128'd1);
        check("abort_busy", 128'(m_busy), 128'd0);
        check("abort_out_valid", 128'(m_out_valid), 128'd0);
        k = -1;
        return;
      end
      if (exp_rnd == reset_rnd) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #1 rst_n = 1'b1;
        tick();
        k = -1;
        return;
      end
      if (mask[exp_rnd] && stalled < 2) begin
        rk_ack = 1'b0;
        stalled++;
      end else begin
        rk_ack  = 1'b1;
        stalled = 0;
        exp_rnd++;
      end
      tick();
      k++;
    end
    rk_ack = 1'b1;
    check("latency", 128'(k), 128'(nr + 1 + 2 * $countones(mask)));
  endtask

  task automatic finish_out(input logic [127:0] exp, input int hold);
    check("out_valid", 128'(m_out_valid), 128'd1);
    check("out_block", m_out_block, exp);
    check("dp_state", m_dp_state, exp);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      tick();
      check("hold_valid", 128'(m_out_valid), 128'd1);
      check("hold_block", m_out_block, exp);
      check("hold_in_ready", 128'(m_in_ready), 128'd0);
    end
    out_ready = 1'b1;
    check("hs_in_ready", 128'(m_in_ready), 128'd0);
    tick();
    out_ready = 1'b0;
    check("post_in_ready", 128'(m_in_ready), 128'd1);
    check("post_out_valid", 128'(m_out_valid), 128'd0);
    check("post_rk_req", 128'(m_rk_req), 128'd0);
    check("post_dp_final", 128'(m_dp_final), 128'd0);
  endtask

  task automatic idle_watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_out_valid", 128'(m_out_valid), 128'd0);
      check("idle_busy", 128'(m_busy), 128'd0);
    end
  endtask

  initial begin
    int k;
    logic [127:0] pt;
    logic [127:0] ex;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    sel14     = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    abort     = 1'b0;
    rk_ack    = 1'b1;
    out_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin
      keytab10[r] = '0;
      keytab14[r] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    expand128(KeyC1);

    #2;
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;
    tick();

    // FIPS-197 C.1 with keys always available
    send(PtC1, CtC1, 1'b0);
    run_key(10, 16'h0000, -1, -1, k);
    finish_out(CtC1, 0);

    // Two-cycle key stalls at rounds 0, 5 and 10, consumer back-pressure for 5 cycles
    send(PtC1, CtC1, 1'b0);
    run_key(10, 16'h0421, -1, -1, k);
    finish_out(CtC1, 5);

    // Abort at round 4 discards the block
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(pt, model(pt, 1'b0), 1'b0);
    run_key(10, 16'h0000, 4, -1, k);
    void'(exp_q.pop_back());
    idle_watch(4);

    // Abort held while idle must not block acceptance; the next vector still encrypts
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    ex = model(pt, 1'b0);
    send(pt, ex, 1'b1);
    run_key(10, 16'h0000, -1, -1, k);
    finish_out(ex, 1);

    // Reset pulse at round 7 discards the block
    send(PtC1, CtC1, 1'b0);
    run_key(10, 16'h0000, -1, 7, k);
    void'(exp_q.pop_back());
    idle_watch(5);

    // NR=14 instance: full index sweep, final round flagged only at 14
    sel14 = 1'b1;
    tick();
    pt = {$urandom(), $urandom(), $urandom(), $urandom()};
    ex = model(pt, 1'b1);
    send(pt, ex, 1'b0);
    run_key(14, 16'h4000, -1, -1, k);
    finish_out(ex, 2);

    check("sb_drain", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
